// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the memory arbiter's state encoding.
package cpu_types_pkg;

    localparam int unsigned WORD_WIDTH = 32;

    typedef logic [WORD_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        IACC,
        DACC
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) to single-RAM arbiter; data wins ties unless it
// was served last, so a busy data side cannot starve instruction fetch.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W = $bits(word_t)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramack
);

    arb_state_t        state;
    arb_state_t        next_state;
    logic              last_d;
    logic [WORD_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_store;
    logic              lat_wr;
    logic              d_req;
    logic              i_done;
    logic              d_done;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            lat_addr  <= '0;
            lat_store <= '0;
            lat_wr    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == DACC) begin
                lat_addr  <= daddr;
                lat_store <= dstore;
                lat_wr    <= dWEN;
            end else if (state == IDLE && next_state == IACC) begin
                lat_addr  <= iaddr;
                lat_store <= '0;
                lat_wr    <= 1'b0;
            end
            if (i_done) begin
                last_d <= 1'b0;
            end else if (d_done) begin
                last_d <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        d_req      = dREN | dWEN;
        // A reset cycle never reports completion, even if the RAM acks.
        i_done     = (state == IACC) && ramack && nRST;
        d_done     = (state == DACC) && ramack && nRST;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = lat_addr;
        ramstore   = lat_store;
        iwait      = iREN && !i_done;
        dwait      = d_req && !d_done;
        iload      = '0;
        dload      = '0;

        unique case (state)
            IDLE: begin
                if (d_req && iREN && last_d) begin
                    next_state = IACC;
                end else if (d_req) begin
                    next_state = DACC;
                end else if (iREN) begin
                    next_state = IACC;
                end
            end
            IACC: begin
                ramREN = 1'b1;
                if (ramack) begin
                    next_state = IDLE;
                end
            end
            DACC: begin
                ramREN = !lat_wr;
                ramWEN = lat_wr;
                if (ramack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        // Completed data is dropped if the requester has already walked away.
        if (i_done && iREN) begin
            iload = ramload;
        end
        if (d_done && d_req && !lat_wr) begin
            dload = ramload;
        end
    end

endmodule
